// File: rtl/alarm_trigger.sv
// alarm_trigger
//
// Decides when the stored alarm rings and manages snooze, stop and the
// ring auto-timeout. Sits downstream of the alarm register block. Its
// outputs feed the buzzer/LED stage and the display mode indicator.
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-low reset
//   enabled        alarm function enable; low forces IDLE
//   tick_1hz       one-clk pulse per second, aligned with the seconds increment
//   cur_hours      current time, hours 0..23
//   cur_minutes    current time, minutes 0..59
//   cur_seconds    current time, seconds 0..59
//   alarm_hours    alarm hours 0..23, or NOALARM
//   alarm_minutes  alarm minutes 0..59
//   stop_btn       debounced one-clk pulse
//   snooze_btn     debounced one-clk pulse
//   ringing        high while in RINGING
//   snoozing       high while in SNOOZE
//   alarm_event    one-clk pulse on IDLE->RINGING
//   snooze_count   snoozes used in the current alarm event
//   dbg_state      current FSM state (0 IDLE, 1 RINGING, 2 SNOOZE, 3 DONE)
//
// Interface timing: there is no valid/ready handshake here. Buttons and
// tick_1hz are single-clk pulses sampled on the rising edge. Every output
// is a register, so a response shows up one clk after its cause.

module alarm_trigger #(
    parameter logic [4:0] NOALARM        = 5'd24,
    parameter int         RING_SECONDS   = 60,
    parameter int         SNOOZE_MINUTES = 5,
    parameter int         MAX_SNOOZE     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enabled,
    input  logic       tick_1hz,
    input  logic [4:0] cur_hours,
    input  logic [5:0] cur_minutes,
    input  logic [5:0] cur_seconds,
    input  logic [4:0] alarm_hours,
    input  logic [5:0] alarm_minutes,
    input  logic       stop_btn,
    input  logic       snooze_btn,
    output logic       ringing,
    output logic       snoozing,
    output logic       alarm_event,
    output logic [1:0] snooze_count,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [5:0] RING_LAST = 6'(RING_SECONDS - 1);
    localparam logic [9:0] SNZ_LOAD  = 10'(SNOOZE_MINUTES * 60);
    localparam logic [1:0] SNZ_MAX   = 2'(MAX_SNOOZE);

    state_t     state_q;
    logic       ringing_q;
    logic       snoozing_q;
    logic       alarm_event_q;
    logic [1:0] snooze_count_q;
    logic [5:0] ring_cnt_q;
    logic [9:0] snz_cnt_q;

    logic alarm_valid;
    logic minute_match;
    logic match;
    logic force_idle;

    assign alarm_valid  = (alarm_hours != NOALARM);
    assign minute_match = (cur_hours == alarm_hours) && (cur_minutes == alarm_minutes);
    assign match        = alarm_valid && minute_match && (cur_seconds == 6'd0);
    // Disabling the function or clearing the alarm overrides every transition.
    assign force_idle   = !enabled || !alarm_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            ringing_q      <= 1'b0;
            snoozing_q     <= 1'b0;
            alarm_event_q  <= 1'b0;
            snooze_count_q <= 2'd0;
            ring_cnt_q     <= 6'd0;
            snz_cnt_q      <= 10'd0;
        end else begin
            alarm_event_q <= 1'b0;
            if (force_idle) begin
                state_q        <= ST_IDLE;
                ringing_q      <= 1'b0;
                snoozing_q     <= 1'b0;
                snooze_count_q <= 2'd0;
                ring_cnt_q     <= 6'd0;
                snz_cnt_q      <= 10'd0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (match) begin
                            state_q        <= ST_RINGING;
                            ringing_q      <= 1'b1;
                            alarm_event_q  <= 1'b1;
                            ring_cnt_q     <= 6'd0;
                            snooze_count_q <= 2'd0;
                        end
                    end
                    ST_RINGING: begin
                        if (stop_btn) begin
                            state_q   <= ST_DONE;
                            ringing_q <= 1'b0;
                        end else if (snooze_btn && (snooze_count_q < SNZ_MAX)) begin
                            state_q        <= ST_SNOOZE;
                            ringing_q      <= 1'b0;
                            snoozing_q     <= 1'b1;
                            snooze_count_q <= snooze_count_q + 2'd1;
                            snz_cnt_q      <= SNZ_LOAD;
                        end else if (tick_1hz) begin
                            // An exhausted snooze press is ignored, so the tick still counts.
                            if (ring_cnt_q == RING_LAST) begin
                                state_q   <= ST_DONE;
                                ringing_q <= 1'b0;
                            end else begin
                                ring_cnt_q <= ring_cnt_q + 6'd1;
                            end
                        end
                    end
                    ST_SNOOZE: begin
                        if (stop_btn) begin
                            state_q    <= ST_DONE;
                            snoozing_q <= 1'b0;
                        end else if (tick_1hz) begin
                            if (snz_cnt_q == 10'd1) begin
                                // Back to ringing without a new alarm_event pulse.
                                state_q    <= ST_RINGING;
                                snoozing_q <= 1'b0;
                                ringing_q  <= 1'b1;
                                ring_cnt_q <= 6'd0;
                            end else begin
                                snz_cnt_q <= snz_cnt_q - 10'd1;
                            end
                        end
                    end
                    ST_DONE: begin
                        // Hold off until the alarm minute has passed so the
                        // same minute cannot retrigger.
                        if (!minute_match) begin
                            state_q        <= ST_IDLE;
                            snooze_count_q <= 2'd0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign ringing      = ringing_q;
    assign snoozing     = snoozing_q;
    assign alarm_event  = alarm_event_q;
    assign snooze_count = snooze_count_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_alarm_trigger.sv
module tb_alarm_trigger;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RING = 2'd1;
    localparam logic [1:0] S_SNZ  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic       clk;
    logic       reset;
    logic       enabled;
    logic       tick_1hz;
    logic [4:0] cur_hours;
    logic [5:0] cur_minutes;
    logic [5:0] cur_seconds;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic       stop_btn;
    logic       snooze_btn;
    logic       ringing;
    logic       snoozing;
    logic       alarm_event;
    logic [1:0] snooze_count;
    logic [1:0] dbg_state;

    // {state, ringing, snoozing, alarm_event, snooze_count}
    logic [6:0] obs;
    assign obs = {dbg_state, ringing, snoozing, alarm_event, snooze_count};

    int n_checks = 0;
    int n_fail   = 0;

    alarm_trigger #(
        .NOALARM(5'd24), .RING_SECONDS(60), .SNOOZE_MINUTES(5), .MAX_SNOOZE(3)
    ) dut (
        .clk(clk), .reset(reset), .enabled(enabled), .tick_1hz(tick_1hz),
        .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
        .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
        .stop_btn(stop_btn), .snooze_btn(snooze_btn),
        .ringing(ringing), .snoozing(snoozing), .alarm_event(alarm_event),
        .snooze_count(snooze_count), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        cur_hours = h; cur_minutes = m; cur_seconds = s;
    endtask

    task automatic bump_time();
        if (cur_seconds == 6'd59) begin
            cur_seconds = 6'd0;
            if (cur_minutes == 6'd59) begin
                cur_minutes = 6'd0;
                cur_hours   = (cur_hours == 5'd23) ? 5'd0 : cur_hours + 5'd1;
            end else begin
                cur_minutes = cur_minutes + 6'd1;
            end
        end else begin
            cur_seconds = cur_seconds + 6'd1;
        end
    endtask

    // Tick is seen with the old time; the incremented time follows a clk later.
    task automatic advance_second();
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        bump_time();
        @(negedge clk);
    endtask

    task automatic press(input logic stop, input logic snz, input logic tick);
        stop_btn = stop; snooze_btn = snz; tick_1hz = tick;
        @(negedge clk);
        stop_btn = 1'b0; snooze_btn = 1'b0; tick_1hz = 1'b0;
    endtask

    // Clears the FSM via enabled, then steps 07:29:59 -> 07:30:00 with alarm 07:30.
    task automatic start_ring(input string tag);
        enabled = 1'b0;
        alarm_hours = 5'd7; alarm_minutes = 6'd30;
        set_time(5'd7, 6'd29, 6'd59);
        @(negedge clk);
        enabled = 1'b1;
        @(negedge clk);
        advance_second();
        n_checks++;
        if (obs !== {S_RING, 1'b1, 1'b0, 1'b1, 2'd0}) begin
            n_fail++; $display("FAIL %s_start: obs=%b exp=%b", tag, obs, {S_RING, 1'b1, 1'b0, 1'b1, 2'd0});
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        enabled = 1'b1;
        set_time(5'd7, 6'd30, 6'd0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs !== 7'b0) begin n_fail++; $display("FAIL reset_hold: obs=%b exp=%b", obs, 7'b0); end
        set_time(5'd7, 6'd29, 6'd59);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs !== 7'b0) begin n_fail++; $display("FAIL reset_release: obs=%b exp=%b", obs, 7'b0); end
    endtask

    task automatic test_ring_timeout();
        start_ring("t1");
        @(negedge clk);
        n_checks++;
        if (obs !== {S_RING, 1'b1, 1'b0, 1'b0, 2'd0}) begin
            n_fail++; $display("FAIL t1_event_one_clk: obs=%b exp=%b", obs, {S_RING, 1'b1, 1'b0, 1'b0, 2'd0});
        end
        repeat (59) advance_second();
        n_checks++;
        if (obs !== {S_RING, 1'b1, 1'b0, 1'b0, 2'd0}) begin
            n_fail++; $display("FAIL t1_59_ticks: obs=%b exp=%b", obs, {S_RING, 1'b1, 1'b0, 1'b0, 2'd0});
        end
        press(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (obs !== {S_DONE, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            n_fail++; $display("FAIL t1_timeout: obs=%b exp=%b", obs, {S_DONE, 1'b0, 1'b0, 1'b0, 2'd0});
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs !== {S_DONE, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            n_fail++; $display("FAIL t1_done_hold: obs=%b exp=%b", obs, {S_DONE, 1'b0, 1'b0, 1'b0, 2'd0});
        end
        bump_time();  // 07:31:00
        @(negedge clk);
        n_checks++;
        if (obs !== {S_IDLE, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            n_fail++; $display("FAIL t1_idle_0731: obs=%b exp=%b", obs, {S_IDLE, 1'b0, 1'b0, 1'b0, 2'd0});
        end
    endtask

    task automatic test_snooze();
        start_ring("t2");
        press(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (obs !== {S_SNZ, 1'b0, 1'b1, 1'b0, 2'd1}) begin
            n_fail++; $display("FAIL t2_enter: obs=%b exp=%b", obs, {S_SNZ, 1'b0, 1'b1, 1'b0, 2'd1});
        end
        repeat (299) advance_second();
        n_checks++;
        if (obs !== {S_SNZ, 1'b0, 1'b1, 1'b0, 2'd1}) begin
            n_fail++; $display("FAIL t2_299: obs=%b exp=%b", obs, {S_SNZ, 1'b0, 1'b1, 1'b0, 2'd1});
        end
        press(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (obs !== {S_RING, 1'b1, 1'b0, 1'b0, 2'd1}) begin
            n_fail++; $display("FAIL t2_expire_no_event: obs=%b exp=%b", obs, {S_RING, 1'b1, 1'b0, 1'b0, 2'd1});
        end
        bump_time();
        @(negedge clk);
    endtask

    // Continues from test_snooze: ringing again with one snooze used.
    task automatic test_max_snooze();
        for (int k = 2; k <= 3; k++) begin
            press(1'b0, 1'b1, 1'b0);
            n_checks++;
            if (obs !== {S_SNZ, 1'b0, 1'b1, 1'b0, 2'(k)}) begin
                n_fail++; $display("FAIL t3_snz%0d: obs=%b exp=%b", k, obs, {S_SNZ, 1'b0, 1'b1, 1'b0, 2'(k)});
            end
            repeat (300) advance_second();
            n_checks++;
            if (obs !== {S_RING, 1'b1, 1'b0, 1'b0, 2'(k)}) begin
                n_fail++; $display("FAIL t3_ring%0d: obs=%b exp=%b", k, obs, {S_RING, 1'b1, 1'b0, 1'b0, 2'(k)});
            end
        end
        press(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (obs !== {S_RING, 1'b1, 1'b0, 1'b0, 2'd3}) begin
            n_fail++; $display("FAIL t3_4th_ignored: obs=%b exp=%b", obs, {S_RING, 1'b1, 1'b0, 1'b0, 2'd3});
        end
        press(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (obs !== {S_DONE, 1'b0, 1'b0, 1'b0, 2'd3}) begin
            n_fail++; $display("FAIL t3_stop: obs=%b exp=%b", obs, {S_DONE, 1'b0, 1'b0, 1'b0, 2'd3});
        end
        @(negedge clk);  // time is ~07:45, so DONE releases
        n_checks++;
        if (obs !== {S_IDLE, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            n_fail++; $display("FAIL t3_idle_clear: obs=%b exp=%b", obs, {S_IDLE, 1'b0, 1'b0, 1'b0, 2'd0});
        end
    endtask

    task automatic test_simultaneous();
        start_ring("t4a");
        press(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (obs !== {S_DONE, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            n_fail++; $display("FAIL t4_stop_snz: obs=%b exp=%b", obs, {S_DONE, 1'b0, 1'b0, 1'b0, 2'd0});
        end
        repeat (3) advance_second();  // still 07:30:xx, must not retrigger
        n_checks++;
        if (obs !== {S_DONE, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            n_fail++; $display("FAIL t4_no_retrigger: obs=%b exp=%b", obs, {S_DONE, 1'b0, 1'b0, 1'b0, 2'd0});
        end
        start_ring("t4b");
        press(1'b1, 1'b0, 1'b1);
        n_checks++;
        if (obs !== {S_DONE, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            n_fail++; $display("FAIL t4_stop_tick: obs=%b exp=%b", obs, {S_DONE, 1'b0, 1'b0, 1'b0, 2'd0});
        end
        // 59 counted ticks, then the timeout tick collides with snooze: snooze wins.
        start_ring("t4c");
        repeat (59) advance_second();
        press(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (obs !== {S_SNZ, 1'b0, 1'b1, 1'b0, 2'd1}) begin
            n_fail++; $display("FAIL t4_snz_tick: obs=%b exp=%b", obs, {S_SNZ, 1'b0, 1'b1, 1'b0, 2'd1});
        end
        press(1'b1, 1'b0, 1'b1);
        @(negedge clk);  // 07:30:59 still the alarm minute, DONE holds the count
        n_checks++;
        if (obs !== {S_DONE, 1'b0, 1'b0, 1'b0, 2'd1}) begin
            n_fail++; $display("FAIL t4_done_count: obs=%b exp=%b", obs, {S_DONE, 1'b0, 1'b0, 1'b0, 2'd1});
        end
        bump_time();
        @(negedge clk);
        n_checks++;
        if (obs !== {S_IDLE, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            n_fail++; $display("FAIL t4_idle: obs=%b exp=%b", obs, {S_IDLE, 1'b0, 1'b0, 1'b0, 2'd0});
        end
    endtask

    task automatic test_alarm_change();
        start_ring("t5a");
        alarm_minutes = 6'd45;
        @(negedge clk);
        n_checks++;
        if (obs !== {S_RING, 1'b1, 1'b0, 1'b0, 2'd0}) begin
            n_fail++; $display("FAIL t5_change_continue: obs=%b exp=%b", obs, {S_RING, 1'b1, 1'b0, 1'b0, 2'd0});
        end
        press(1'b1, 1'b0, 1'b0);
        @(negedge clk);  // 07:30 no longer equals the new 07:45 alarm
        n_checks++;
        if (obs !== {S_IDLE, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            n_fail++; $display("FAIL t5_done_new_value: obs=%b exp=%b", obs, {S_IDLE, 1'b0, 1'b0, 1'b0, 2'd0});
        end
        start_ring("t5b");
        enabled = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs !== 7'b0) begin n_fail++; $display("FAIL t5_disable: obs=%b exp=%b", obs, 7'b0); end
    endtask

    task automatic test_noalarm();
        enabled = 1'b0;
        alarm_hours = 5'd24; alarm_minutes = 6'd0;
        set_time(5'd23, 6'd59, 6'd59);
        @(negedge clk);
        enabled = 1'b1;
        advance_second();  // 00:00:00
        repeat (2) @(negedge clk);
        n_checks++;
        if (obs !== 7'b0) begin n_fail++; $display("FAIL t6_noalarm_midnight: obs=%b exp=%b", obs, 7'b0); end
        start_ring("t6");
        press(1'b0, 1'b1, 1'b0);
        alarm_hours = 5'd24;
        @(negedge clk);
        n_checks++;
        if (obs !== 7'b0) begin n_fail++; $display("FAIL t6_clear_in_snooze: obs=%b exp=%b", obs, 7'b0); end
    endtask

    task automatic test_async_reset();
        start_ring("t7");
        press(1'b0, 1'b1, 1'b0);
        repeat (300) advance_second();
        n_checks++;
        if (obs !== {S_RING, 1'b1, 1'b0, 1'b0, 2'd1}) begin
            n_fail++; $display("FAIL t7_pre: obs=%b exp=%b", obs, {S_RING, 1'b1, 1'b0, 1'b0, 2'd1});
        end
        #2 reset = 1'b0;
        #1;  // still before the next rising edge
        n_checks++;
        if (obs !== 7'b0) begin n_fail++; $display("FAIL t7_async_clear: obs=%b exp=%b", obs, 7'b0); end
        set_time(5'd7, 6'd30, 6'd30);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs !== 7'b0) begin n_fail++; $display("FAIL t7_release_0730_30: obs=%b exp=%b", obs, 7'b0); end
        repeat (2) advance_second();
        n_checks++;
        if (obs !== 7'b0) begin n_fail++; $display("FAIL t7_quiet: obs=%b exp=%b", obs, 7'b0); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset = 1'b0; enabled = 1'b0; tick_1hz = 1'b0;
        stop_btn = 1'b0; snooze_btn = 1'b0;
        alarm_hours = 5'd7; alarm_minutes = 6'd30;
        set_time(5'd0, 6'd0, 6'd0);
        @(negedge clk);
        test_reset();
        test_ring_timeout();
        test_snooze();
        test_max_snooze();
        test_simultaneous();
        test_alarm_change();
        test_noalarm();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_trigger.md
Name: alarm_trigger

Overview:
- Downstream consumer of the 12-hour alarm register block.
- Takes the stored alarm time (24-hour encoded, hours = 24 means no alarm) and the running clock time.
- Decides when the alarm rings, and handles snooze, stop and auto-timeout.
- Its outputs drive the buzzer/LED stage and the display mode indicator.

Parameters:
NOALARM, 5'd24, hours value meaning no alarm is set
RING_SECONDS, 60, seconds of ringing before auto-timeout (1..63)
SNOOZE_MINUTES, 5, snooze length in minutes (1..17)
MAX_SNOOZE, 3, maximum snoozes per alarm event (0..3)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
enabled  input  1  alarm function enable; low forces IDLE
tick_1hz  input  1  one-clk pulse per second, aligned with the seconds increment
cur_hours  input  5  current time, hours 0..23
cur_minutes  input  6  current time, minutes 0..59
cur_seconds  input  6  current time, seconds 0..59
alarm_hours  input  5  alarm hours 0..23, or NOALARM
alarm_minutes  input  6  alarm minutes 0..59
stop_btn  input  1  debounced one-clk pulse
snooze_btn  input  1  debounced one-clk pulse
ringing  output  1  high while in RINGING
snoozing  output  1  high while in SNOOZE
alarm_event  output  1  one-clk pulse on IDLE->RINGING
snooze_count  output  2  snoozes used in the current event

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all outputs 0; ring_cnt (6b)=0; snz_cnt (10b)=0.
- All outputs are registered; state changes are visible one clk after the causing input.
- match = (alarm_hours != NOALARM) && cur_hours==alarm_hours && cur_minutes==alarm_minutes && cur_seconds==0.
- Global rules:
  - enabled=0 or alarm_hours==NOALARM in any state -> IDLE next clk; snooze_count cleared; counters cleared.
  - This has priority over every transition below.
- IDLE:
  - match -> RINGING; alarm_event=1 for that one clk; ring_cnt=0; snooze_count=0.
  - Buttons ignored.
- RINGING:
  - Priority: stop_btn > snooze_btn > timeout.
  - stop_btn -> DONE.
  - snooze_btn with snooze_count < MAX_SNOOZE -> SNOOZE; snooze_count+1; snz_cnt = SNOOZE_MINUTES*60.
  - snooze_btn with snooze_count == MAX_SNOOZE: ignored, ringing continues.
  - tick_1hz: ring_cnt+1. A tick with ring_cnt == RING_SECONDS-1 -> DONE (timeout).
- SNOOZE:
  - stop_btn -> DONE.
  - snooze_btn ignored.
  - tick_1hz: snz_cnt-1. A tick with snz_cnt==1 -> RINGING, ring_cnt=0.
  - alarm_event is not re-pulsed on snooze expiry.
- DONE:
  - Blocks retrigger while the alarm minute is still current.
  - Returns to IDLE once !(cur_hours==alarm_hours && cur_minutes==alarm_minutes).
  - snooze_count holds its value until leaving DONE, then clears.
- Simultaneous events:
  - stop and snooze in the same clk: stop wins.
  - Button and tick in the same clk: button wins; the tick is not counted.
- Alarm value changed while RINGING/SNOOZE (to a valid time): event continues; DONE then compares against the new value.
- Snooze expiry crossing midnight or the alarm minute: no special handling. Expiry is purely counter-based.
- Counters never wrap. ring_cnt saturates by the timeout transition; snz_cnt is only loaded on snooze entry.

Test Plan:
1. alarm 07:30, time steps 07:29:59 -> 07:30:00 -> ringing=1 and alarm_event pulse 1 clk after cur_seconds==0; then 60 ticks -> DONE, ringing=0; stays quiet for remaining 07:30:xx; IDLE at 07:31:00.
2. Ringing, snooze_btn -> snoozing=1, snooze_count=1; 299 ticks still snoozing; 300th tick -> ringing=1, no alarm_event pulse.
3. Snooze 3 times with MAX_SNOOZE=3 -> snooze_count=3; 4th snooze_btn while ringing -> still ringing; stop_btn -> DONE.
4. stop_btn and snooze_btn asserted same clk while ringing -> DONE, snooze_count unchanged; stop_btn and tick same clk -> DONE, no ring_cnt increment.
5. alarm_hours=24 (NOALARM), time passes 00:00:00 -> never rings. Set alarm during SNOOZE to 24 -> IDLE, all outputs 0 next clk.
6. Drop reset to 0 mid-RINGING, asynchronous to clk -> ringing=0, snooze_count=0 immediately. Release at 07:30:30 -> no ring, since cur_seconds != 0.
